// File: rtl/hw_led_seq_pkg.sv
// Shared definitions for hw_led_sequencer: CSR map, bit positions, FSM states
// and the LENGTH clamp helper.
package hw_led_seq_pkg;

    localparam logic [4:0] CSR_CTRL   = 5'd0;
    localparam logic [4:0] CSR_STATUS = 5'd1;
    localparam logic [4:0] CSR_PERIOD = 5'd2;
    localparam logic [4:0] CSR_LENGTH = 5'd3;
    localparam logic [4:0] CSR_DIRECT = 5'd4;
    localparam logic [4:0] CSR_TABLE  = 5'd16;

    localparam int CTRL_RUN       = 0;
    localparam int CTRL_LOOP      = 1;
    localparam int CTRL_IRQ_EN    = 2;
    localparam int STATUS_BUSY    = 0;
    localparam int STATUS_DONE    = 1;
    localparam int STATUS_IDX_LSB = 4;

    localparam int              LEN_W   = 5;
    localparam logic [LEN_W-1:0] LEN_MIN = 5'd1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT
    } seq_state_t;

    // Zero means a single step; anything beyond the table size plays the whole table.
    function automatic logic [LEN_W-1:0] clamp_length(input logic [LEN_W-1:0] len,
                                                      input logic [LEN_W-1:0] max_len);
        if (len == '0)
            return LEN_MIN;
        else if (len > max_len)
            return max_len;
        else
            return len;
    endfunction

endpackage

// File: rtl/hw_led_seq_arb.sv
// Two-way round-robin arbiter (CPU direct write vs. step engine) driving a
// registered one-cycle PIO write strobe.
module hw_led_seq_arb (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       direct_req,
    input  logic [7:0] direct_data,
    input  logic       step_req,
    input  logic [7:0] step_data,
    output logic       direct_gnt,
    output logic       step_gnt,
    output logic       pio_chipselect,
    output logic       pio_write_n,
    output logic [7:0] pio_data
);

    logic last_step;
    logic direct_ok;
    logic step_ok;

    // A requester whose strobe is on the bus this cycle sits out, so the same
    // source never produces two strobes in a row.
    always_comb begin
        direct_ok  = direct_req && !(pio_chipselect && !last_step);
        step_ok    = step_req && !(pio_chipselect && last_step);
        direct_gnt = direct_ok && (!step_ok || last_step);
        step_gnt   = step_ok && !direct_gnt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pio_chipselect <= 1'b0;
            pio_write_n    <= 1'b1;
            pio_data       <= '0;
            last_step      <= 1'b1;
        end else begin
            pio_chipselect <= direct_gnt || step_gnt;
            pio_write_n    <= !(direct_gnt || step_gnt);
            if (direct_gnt) begin
                pio_data  <= direct_data;
                last_step <= 1'b0;
            end else if (step_gnt) begin
                pio_data  <= step_data;
                last_step <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/hw_led_sequencer.sv
// LED pattern sequencer and PIO write arbiter between the CPU and a timed step engine.
// Completion interrupt is built only when HW_LED_SEQ_IRQ_EN is defined.
module hw_led_sequencer #(
    parameter int DEPTH  = 8,
    parameter int TICK_W = 24
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  csr_address,
    input  logic        csr_chipselect,
    input  logic        csr_write_n,
    input  logic [31:0] csr_writedata,
    output logic [31:0] csr_readdata,
    output logic [1:0]  pio_address,
    output logic        pio_chipselect,
    output logic        pio_write_n,
    output logic [31:0] pio_writedata,
    output logic        irq
);
    import hw_led_seq_pkg::*;

    localparam int               IDX_W   = $clog2(DEPTH);
    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

    seq_state_t        state, state_next;
    logic [LEN_W-1:0]  idx, idx_next;
    logic [TICK_W-1:0] cnt, cnt_next;
    logic              run, loop, done;
    logic [TICK_W-1:0] period;
    logic [LEN_W-1:0]  length;
    logic              direct_pend;
    logic [7:0]        direct_data;
    logic [7:0]        pattern [DEPTH];
    logic [7:0]        pio_data;
    logic              direct_gnt, step_gnt;
    logic              csr_wr, wr_ctrl, tbl_hit, run_start, run_abort, seq_done;
    logic [TICK_W-1:0] period_eff;
    logic [LEN_W-1:0]  len_eff;
    logic              unused_wdata;

    assign csr_wr     = csr_chipselect && !csr_write_n;
    assign wr_ctrl    = csr_wr && (csr_address == CSR_CTRL);
    assign tbl_hit    = csr_address[4] && ({1'b0, csr_address[3:0]} < DEPTH_L);
    assign run_start  = wr_ctrl && csr_writedata[CTRL_RUN] && !run;
    assign run_abort  = wr_ctrl && !csr_writedata[CTRL_RUN] && run;
    assign period_eff = (period == '0) ? TICK_W'(1) : period;
    assign len_eff    = clamp_length(length, DEPTH_L);
    assign unused_wdata = &{1'b0, csr_writedata};

    assign pio_address   = 2'b00;
    assign pio_writedata = {24'b0, pio_data};

    hw_led_seq_arb u_arb (
        .clk            (clk),
        .reset_n        (reset_n),
        .direct_req     (direct_pend),
        .direct_data    (direct_data),
        .step_req       (state == ST_REQ),
        .step_data      (pattern[idx[IDX_W-1:0]]),
        .direct_gnt     (direct_gnt),
        .step_gnt       (step_gnt),
        .pio_chipselect (pio_chipselect),
        .pio_write_n    (pio_write_n),
        .pio_data       (pio_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            cnt   <= cnt_next;
        end
    end

    // A CPU abort overrides everything except a grant already taken this cycle,
    // which the arbiter registers regardless of the state change.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        cnt_next   = cnt;
        seq_done   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (run_start) begin
                    state_next = ST_REQ;
                    idx_next   = '0;
                end
            end
            ST_REQ: begin
                if (step_gnt) begin
                    state_next = ST_WAIT;
                    cnt_next   = '0;
                end
            end
            ST_WAIT: begin
                if (cnt >= period_eff - TICK_W'(1)) begin
                    if ((idx + LEN_W'(1)) < len_eff) begin
                        idx_next   = idx + LEN_W'(1);
                        state_next = ST_REQ;
                    end else if (loop) begin
                        idx_next   = '0;
                        state_next = ST_REQ;
                    end else begin
                        state_next = ST_IDLE;
                        seq_done   = 1'b1;
                    end
                end else begin
                    cnt_next = cnt + TICK_W'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (run_abort) begin
            state_next = ST_IDLE;
            idx_next   = idx;
            seq_done   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run         <= 1'b0;
            loop        <= 1'b0;
            done        <= 1'b0;
            period      <= '0;
            length      <= '0;
            direct_pend <= 1'b0;
            direct_data <= '0;
        end else begin
            if (csr_wr) begin
                case (csr_address)
                    CSR_CTRL: begin
                        run  <= csr_writedata[CTRL_RUN];
                        loop <= csr_writedata[CTRL_LOOP];
                    end
                    CSR_PERIOD: period <= csr_writedata[TICK_W-1:0];
                    CSR_LENGTH: length <= csr_writedata[LEN_W-1:0];
                    default: ;
                endcase
            end
            if (seq_done)
                run <= 1'b0;
            if (seq_done)
                done <= 1'b1;
            else if (csr_wr && (csr_address == CSR_STATUS) && csr_writedata[STATUS_DONE])
                done <= 1'b0;
            if (csr_wr && (csr_address == CSR_DIRECT)) begin
                direct_pend <= 1'b1;
                direct_data <= csr_writedata[7:0];
            end else if (direct_gnt) begin
                direct_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++)
                pattern[i] <= '0;
        end else if (csr_wr && tbl_hit) begin
            pattern[csr_address[IDX_W-1:0]] <= csr_writedata[7:0];
        end
    end

`ifdef HW_LED_SEQ_IRQ_EN
    logic irq_en;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en <= 1'b0;
            irq    <= 1'b0;
        end else begin
            if (wr_ctrl)
                irq_en <= csr_writedata[CTRL_IRQ_EN];
            irq <= done && irq_en;
        end
    end
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        csr_readdata = '0;
        case (csr_address)
            CSR_CTRL: begin
                csr_readdata[CTRL_RUN]  = run;
                csr_readdata[CTRL_LOOP] = loop;
`ifdef HW_LED_SEQ_IRQ_EN
                csr_readdata[CTRL_IRQ_EN] = irq_en;
`endif
            end
            CSR_STATUS: begin
                csr_readdata[STATUS_BUSY]                  = (state != ST_IDLE);
                csr_readdata[STATUS_DONE]                  = done;
                csr_readdata[STATUS_IDX_LSB +: LEN_W]      = idx;
            end
            CSR_PERIOD: csr_readdata[TICK_W-1:0] = period;
            CSR_LENGTH: csr_readdata[LEN_W-1:0]  = length;
            CSR_DIRECT: csr_readdata[7:0]        = pio_data;
            default: begin
                if (tbl_hit)
                    csr_readdata[7:0] = pattern[csr_address[IDX_W-1:0]];
            end
        endcase
    end

endmodule

// File: tb/tb_hw_led_sequencer.sv
// Scoreboard bench for hw_led_sequencer: expected PIO strobes (data and cycle)
// are queued by the stimulus and popped by an independent bus monitor.
`timescale 1ns/1ps
module tb_hw_led_sequencer;
    import hw_led_seq_pkg::*;

    localparam int DEPTH  = 8;
    localparam int TICK_W = 24;
`ifdef HW_LED_SEQ_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif
    localparam logic [31:0] CTRL_IRQ_RB = IRQ_ON ? 32'h4 : 32'h0;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [4:0]  csr_address = '0;
    logic        csr_chipselect = 1'b0;
    logic        csr_write_n = 1'b1;
    logic [31:0] csr_writedata = '0;
    logic [31:0] csr_readdata;
    logic [1:0]  pio_address;
    logic        pio_chipselect;
    logic        pio_write_n;
    logic [31:0] pio_writedata;
    logic        irq;

    typedef struct {
        logic [31:0] data;
        int          cycle;
    } strobe_t;

    strobe_t exp_q[$];
    int      checks = 0;
    int      errors = 0;
    int      cyc = 0;

    hw_led_sequencer #(.DEPTH(DEPTH), .TICK_W(TICK_W)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .csr_address    (csr_address),
        .csr_chipselect (csr_chipselect),
        .csr_write_n    (csr_write_n),
        .csr_writedata  (csr_writedata),
        .csr_readdata   (csr_readdata),
        .pio_address    (pio_address),
        .pio_chipselect (pio_chipselect),
        .pio_write_n    (pio_write_n),
        .pio_writedata  (pio_writedata),
        .irq            (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor: every strobe seen on the PIO side must match the queue head.
    always @(negedge clk) begin
        strobe_t e;
        if (reset_n && pio_chipselect && !pio_write_n) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_strobe: got data=%h at cycle %0d, required no strobe",
                         pio_writedata, cyc);
            end else begin
                e = exp_q.pop_front();
                if (pio_writedata !== e.data || cyc != e.cycle || pio_address !== 2'b00) begin
                    errors++;
                    $display("[TB] FAIL pio_strobe: got data=%h cycle=%0d addr=%0d, required data=%h cycle=%0d addr=0",
                             pio_writedata, cyc, pio_address, e.data, e.cycle);
                end
            end
        end
    end

    function automatic void expectStrobe(input logic [7:0] d, input int c);
        strobe_t e;
        e.data  = {24'b0, d};
        e.cycle = c;
        exp_q.push_back(e);
    endfunction

    // One CSR write, captured on the next rising edge; returns at the following negedge.
    task automatic applyStimulus(input logic [4:0] addr, input logic [31:0] data);
        csr_address    = addr;
        csr_writedata  = data;
        csr_chipselect = 1'b1;
        csr_write_n    = 1'b0;
        @(negedge clk);
        csr_chipselect = 1'b0;
        csr_write_n    = 1'b1;
    endtask

    task automatic checkOutput(input logic [4:0] addr, input logic [31:0] exp,
                               input logic [31:0] mask, input string name);
        csr_address = addr;
        #1;
        checks++;
        if ((csr_readdata & mask) !== (exp & mask)) begin
            errors++;
            $display("[TB] FAIL %s: read %h, required %h (mask %h)", name, csr_readdata, exp, mask);
        end
    endtask

    task automatic checkPin(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int w;
        repeat (3) @(negedge clk);
        checkPin("rst_pio_cs", 32'(pio_chipselect), 32'h0);
        checkPin("rst_pio_wn", 32'(pio_write_n), 32'h1);
        checkPin("rst_pio_data", pio_writedata, 32'h0);
        checkPin("rst_irq", 32'(irq), 32'h0);
        reset_n = 1'b1;
        checkOutput(CSR_CTRL,   32'h0, '1, "rst_ctrl");
        checkOutput(CSR_STATUS, 32'h0, '1, "rst_status");
        checkOutput(CSR_PERIOD, 32'h0, '1, "rst_period");
        checkOutput(CSR_DIRECT, 32'h0, '1, "rst_direct");
        @(negedge clk);

        $display("[TB] one-shot table 01/02/04, PERIOD=4");
        applyStimulus(CSR_TABLE,         32'h01);
        applyStimulus(CSR_TABLE + 5'd1,  32'h02);
        applyStimulus(CSR_TABLE + 5'd2,  32'h04);
        applyStimulus(CSR_LENGTH, 32'd3);
        applyStimulus(CSR_PERIOD, 32'd4);
        applyStimulus(CSR_CTRL,   32'h5);
        w = cyc;
        expectStrobe(8'h01, w + 1);
        expectStrobe(8'h02, w + 6);
        expectStrobe(8'h04, w + 11);
        waitCycles(3);
        checkOutput(CSR_STATUS, 32'h01, '1, "a_status_busy");
        waitCycles(12);
        checkOutput(CSR_STATUS, 32'h22, '1, "a_status_done");
        checkOutput(CSR_CTRL, CTRL_IRQ_RB, '1, "a_run_cleared");
        checkPin("a_irq_low", 32'(irq), 32'h0);
        waitCycles(1);
        checkPin("a_irq_rise", 32'(irq), 32'(IRQ_ON));
        applyStimulus(CSR_STATUS, 32'h2);
        checkOutput(CSR_STATUS, 32'h20, '1, "a_done_w1c");
        checkPin("a_irq_hold", 32'(irq), 32'(IRQ_ON));
        waitCycles(1);
        checkPin("a_irq_fall", 32'(irq), 32'h0);

        $display("[TB] loop AA/55, PERIOD=1, aborts");
        applyStimulus(CSR_TABLE,        32'hAA);
        applyStimulus(CSR_TABLE + 5'd1, 32'h55);
        applyStimulus(CSR_LENGTH, 32'd2);
        applyStimulus(CSR_PERIOD, 32'd1);
        applyStimulus(CSR_CTRL,   32'h3);
        w = cyc;
        expectStrobe(8'hAA, w + 1);
        expectStrobe(8'h55, w + 3);
        expectStrobe(8'hAA, w + 5);
        expectStrobe(8'h55, w + 7);
        waitCycles(7);
        applyStimulus(CSR_CTRL, 32'h2);
        waitCycles(4);
        checkOutput(CSR_CTRL,   32'h2, '1, "b_abort_ctrl");
        checkOutput(CSR_STATUS, 32'h0, 32'h3, "b_abort_idle");
        applyStimulus(CSR_CTRL, 32'h3);
        w = cyc;
        expectStrobe(8'hAA, w + 1);
        expectStrobe(8'h55, w + 3);
        waitCycles(2);
        applyStimulus(CSR_CTRL, 32'h2);
        waitCycles(4);
        checkOutput(CSR_STATUS, 32'h0, 32'h3, "b_grant_abort_idle");

        $display("[TB] DIRECT contends with step request");
        applyStimulus(CSR_TABLE,        32'h18);
        applyStimulus(CSR_TABLE + 5'd1, 32'h81);
        applyStimulus(CSR_PERIOD, 32'd2);
        applyStimulus(CSR_CTRL,   32'h1);
        w = cyc;
        expectStrobe(8'h18, w + 1);
        expectStrobe(8'h3C, w + 4);
        expectStrobe(8'h81, w + 5);
        waitCycles(2);
        applyStimulus(CSR_DIRECT, 32'h3C);
        waitCycles(4);
        checkOutput(CSR_DIRECT, 32'h81, '1, "d_direct_readback");
        checkOutput(CSR_STATUS, 32'h12, '1, "d_status_done");

        $display("[TB] DIRECT replaced while losing arbitration");
        applyStimulus(CSR_TABLE,        32'h42);
        applyStimulus(CSR_TABLE + 5'd1, 32'h24);
        applyStimulus(CSR_PERIOD, 32'd4);
        applyStimulus(CSR_CTRL,   32'h1);
        w = cyc;
        expectStrobe(8'h42, w + 1);
        expectStrobe(8'h99, w + 3);
        expectStrobe(8'h24, w + 6);
        expectStrobe(8'h22, w + 7);
        waitCycles(1);
        applyStimulus(CSR_DIRECT, 32'h99);
        waitCycles(2);
        applyStimulus(CSR_DIRECT, 32'h11);
        applyStimulus(CSR_DIRECT, 32'h22);
        waitCycles(5);
        checkOutput(CSR_DIRECT, 32'h22, '1, "e_direct_latest");
        checkOutput(CSR_STATUS, 32'h12, '1, "e_status_done");

        $display("[TB] PERIOD=0, LENGTH=0");
        applyStimulus(CSR_STATUS, 32'h2);
        applyStimulus(CSR_TABLE,  32'h77);
        applyStimulus(CSR_PERIOD, 32'd0);
        applyStimulus(CSR_LENGTH, 32'd0);
        applyStimulus(CSR_CTRL,   32'h5);
        w = cyc;
        expectStrobe(8'h77, w + 1);
        waitCycles(2);
        checkOutput(CSR_STATUS, 32'h02, '1, "f_status_done");
        checkPin("f_irq_low", 32'(irq), 32'h0);
        waitCycles(1);
        checkPin("f_irq_rise", 32'(irq), 32'(IRQ_ON));
        applyStimulus(CSR_STATUS, 32'h2);
        checkOutput(CSR_STATUS, 32'h0, '1, "f_done_w1c");
        checkPin("f_irq_hold", 32'(irq), 32'(IRQ_ON));
        waitCycles(1);
        checkPin("f_irq_fall", 32'(irq), 32'h0);

        $display("[TB] reset during a running sequence");
        applyStimulus(CSR_PERIOD, 32'd3);
        applyStimulus(CSR_LENGTH, 32'd2);
        applyStimulus(CSR_CTRL,   32'h3);
        w = cyc;
        expectStrobe(8'h77, w + 1);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checkPin("g_rst_pio_cs", 32'(pio_chipselect), 32'h0);
        checkPin("g_rst_pio_wn", 32'(pio_write_n), 32'h1);
        checkPin("g_rst_pio_data", pio_writedata, 32'h0);
        checkPin("g_rst_irq", 32'(irq), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        checkOutput(CSR_STATUS, 32'h0, '1, "g_status_after_reset");
        checkOutput(CSR_CTRL,   32'h0, '1, "g_ctrl_after_reset");
        waitCycles(10);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++)
            @(negedge clk);
        while (exp_q.size() > 0) begin
            strobe_t e;
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("[TB] FAIL missing_strobe: got none, required data=%h at cycle %0d", e.data, e.cycle);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hw_led_sequencer.md
# hw_led_sequencer

Autonomous LED pattern sequencer and bus arbiter placed between the NIOS data master and the 8-bit LED PIO (`s1`, zero-wait, write-only use). It owns the single master path into the PIO and shares it between two requesters: CPU direct writes (via its own CSR slave) and an internal timer-driven step engine that plays a stored pattern table. Optional completion interrupt to the NIOS.

## Interface
Parameters:
- `DEPTH`, 8: pattern table entries (power of two, 2..16).
- `TICK_W`, 24: width of the step-period counter.

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `csr_address`  in  5  CSR word address.
- `csr_chipselect`  in  1  CSR select.
- `csr_write_n`  in  1  CSR write strobe, active-low.
- `csr_writedata`  in  32  CSR write data.
- `csr_readdata`  out  32  CSR read data, combinational, zero-wait.
- `pio_address`  out  2  to PIO `s1`; always 0.
- `pio_chipselect`  out  1  to PIO, registered.
- `pio_write_n`  out  1  to PIO, registered, active-low.
- `pio_writedata`  out  32  to PIO, registered; bits [31:8] zero.
- `irq`  out  1  level interrupt, registered.

## Operation
- CSR map (word): 0 CTRL {[2] IRQ_EN, [1] LOOP, [0] RUN}; 1 STATUS {[8:4] index, [1] DONE (write-1-to-clear), [0] BUSY}, read-only except DONE; 2 PERIOD [TICK_W-1:0]; 3 LENGTH [4:0]; 4 DIRECT (write: request PIO write; read: last value written to PIO); 16..16+DEPTH-1 pattern table [7:0]. Unmapped reads return 0; unmapped writes are ignored.
- PERIOD = 0 is treated as 1. LENGTH = 0 or LENGTH > DEPTH is clamped to 1 or DEPTH respectively.
- Step engine FSM: IDLE -> REQ on RUN 0->1 (index = 0). REQ holds a step request until granted -> WAIT. WAIT counts PERIOD cycles from the grant. Then: if index+1 < LENGTH, index++ -> REQ; else if LOOP, index = 0 -> REQ; else -> IDLE, DONE=1, RUN cleared by hardware.
- BUSY = FSM not IDLE.
- CPU clearing RUN aborts at the next edge: an ungranted request is dropped, FSM goes to IDLE, DONE unchanged. A strobe already registered completes.
- DIRECT write sets a pending flag with data. A new DIRECT write while pending replaces the data (latest wins); only one PIO write results.
- Arbiter (two requesters): when only one requests, it is granted. When both request, round-robin on last grant; after reset the last grant is "step", so DIRECT wins first. Losing requester is granted the next cycle.
- Grant registers `pio_chipselect`=1, `pio_write_n`=0, `pio_writedata`={24'b0, data} for exactly one cycle. There is never more than one strobe per cycle and never back-to-back strobes from the same requester.
- PERIOD/LENGTH/table writes while BUSY take effect immediately; the next WAIT compare and the next index check use the new values.

## Timing
- Reset values: `pio_chipselect`=0, `pio_write_n`=1, `pio_address`=0, `pio_writedata`=0, `irq`=0, `csr_readdata`=0 (all registers 0, FSM IDLE, DIRECT shadow 0).
- RUN write at edge E -> REQ after E -> strobe cycle starts at E+1 (uncontended), PIO latches at E+2.
- Step-to-step strobe spacing = PERIOD+1 cycles uncontended; +1 per lost arbitration.
- DIRECT write at edge E -> strobe starts at E+1 if uncontended.
- Final step: DONE set on the edge that ends the last WAIT. `irq` rises on the following edge.
- Simultaneous RUN clear and grant: the grant wins, and the strobe is issued.

## Configuration
- `HW_LED_SEQ_IRQ_EN` defined: `irq` = DONE & IRQ_EN, registered. IRQ_EN is readable and writable.
- Not defined: `irq` tied 0, and CTRL[2] reads 0 (writes ignored). DONE status is still maintained.

## Structure
- Package `hw_led_seq_pkg`: CSR offsets, CTRL/STATUS bit indices, FSM state enum, LENGTH clamp constant.
- Sub-module `hw_led_seq_arb`: 2-way round-robin arbiter with registered one-cycle strobe output.
- The pattern table is a flop array (DEPTH x 8).

## Test plan
- Reset mid-sequence (RUN, PERIOD=3) -> PIO outputs go to idle values asynchronously; STATUS reads 0 after release.
- Table {0x01,0x02,0x04}, LENGTH=3, PERIOD=4, LOOP=0, RUN -> PIO writes 0x01,0x02,0x04, spaced 5 cycles; DONE=1; RUN=0; `irq`=1 when IRQ_EN and macro are set.
- LOOP=1, LENGTH=2, PERIOD=1 -> the sequence 0xAA,0x55,0xAA,... continues until RUN is cleared; no strobe after the abort edge.
- DIRECT write 0x3C in the same cycle as a step request 0x81 -> 0x3C strobed first, 0x81 on the next cycle; DIRECT readback = 0x81.
- Two DIRECT writes (0x11, then 0x22) on consecutive cycles while losing arbitration -> only 0x22 is written.
- PERIOD=0, LENGTH=0 -> treated as 1/1: a single strobe, then DONE; a W1C write to DONE clears it, and `irq` drops the next cycle.
